div_issue_ctrl: RTL and testbench

Pipeline-side initiator for the multi-cycle divider. Accepts one divide request at a time from the execute stage over a valid/ready handshake and widens the operands. It launches the divider with a single-cycle start pulse and counts the divider's fixed latency to capture the quotient. The result is returned, tagged, over a second valid/ready handshake. Divide-by-zero and signed overflow are resolved locally without using the divider; a pipeline flush cancels the in-flight operation safely.

---
 rtl/div_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue controller for the multi-cycle divider: accepts one request, launches the
// divider, waits its fixed latency and returns a tagged quotient; handles /0 and overflow locally.
module div_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int DELAY = 8,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_signed,
  input  logic [WIDTH-1:0]   req_dividend,
  input  logic [WIDTH-1:0]   req_divisor,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               div_start,
  output logic               div_is_signed,
  output logic [2*WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic [WIDTH-1:0]   div_quotient,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_quotient,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               resp_div_zero
);

  localparam int CNT_W = $clog2(DELAY + 2);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_signed_q, is_signed_d;
  logic [2*WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_quotient_q, resp_quotient_d;
  logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
  logic               resp_div_zero_q, resp_div_zero_d;

  logic req_fire;
  logic div_by_zero;
  logic sgn_overflow;

  assign req_ready    = (state_q == IDLE) && !flush && !reset;
  assign req_fire     = req_valid && req_ready;
  assign div_by_zero  = (req_divisor == '0);
  assign sgn_overflow = req_signed && (req_dividend == SMIN) && (req_divisor == '1);

  assign div_start     = (state_q == ISSUE) && !flush && !reset;
  assign div_is_signed = is_signed_q;
  assign div_dividend  = dividend_q;
  assign div_divisor   = divisor_q;
  assign resp_valid    = resp_valid_q;
  assign resp_quotient = resp_quotient_q;
  assign resp_tag      = resp_tag_q;
  assign resp_div_zero = resp_div_zero_q;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    is_signed_d     = is_signed_q;
    dividend_d      = dividend_q;
    divisor_d       = divisor_q;
    resp_valid_d    = resp_valid_q;
    resp_quotient_d = resp_quotient_q;
    resp_tag_d      = resp_tag_q;
    resp_div_zero_d = resp_div_zero_q;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          is_signed_d = req_signed;
          dividend_d  = {{WIDTH{req_signed & req_dividend[WIDTH-1]}}, req_dividend};
          divisor_d   = req_divisor;
          resp_tag_d  = req_tag;
          if (div_by_zero) begin
            resp_quotient_d = '1;
            resp_div_zero_d = 1'b1;
            resp_valid_d    = 1'b1;
            state_d         = RESP;
          end else if (sgn_overflow) begin
            resp_quotient_d = req_dividend;
            resp_div_zero_d = 1'b0;
            resp_valid_d    = 1'b1;
            state_d         = RESP;
          end else begin
            resp_div_zero_d = 1'b0;
            state_d         = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(DELAY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A flush here must still let the divider finish before the next launch.
        if (cnt_q == '0) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            resp_quotient_d = div_quotient;
            resp_valid_d    = 1'b1;
            state_d         = RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (flush) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (flush || resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      is_signed_q     <= 1'b0;
      dividend_q      <= '0;
      divisor_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_quotient_q <= '0;
      resp_tag_q      <= '0;
      resp_div_zero_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      is_signed_q     <= is_signed_d;
      dividend_q      <= dividend_d;
      divisor_q       <= divisor_d;
      resp_valid_q    <= resp_valid_d;
      resp_quotient_q <= resp_quotient_d;
      resp_tag_q      <= resp_tag_d;
      resp_div_zero_q <= resp_div_zero_d;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural fixed-latency divider model.
module tb_div_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int DELAY = 8;
  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              reset, flush, req_valid, req_ready, req_signed;
  logic [WIDTH-1:0]  req_dividend, req_divisor;
  logic [TAG_W-1:0]  req_tag;
  logic              div_start, div_is_signed;
  logic [63:0]       div_dividend;
  logic [WIDTH-1:0]  div_divisor, div_quotient;
  logic              resp_valid, resp_ready, resp_div_zero;
  logic [WIDTH-1:0]  resp_quotient;
  logic [TAG_W-1:0]  resp_tag;

  int total = 0;
  int bad   = 0;

  div_issue_ctrl #(.WIDTH(WIDTH), .DELAY(DELAY), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .div_start(div_start), .div_is_signed(div_is_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_quotient(resp_quotient),
    .resp_tag(resp_tag), .resp_div_zero(resp_div_zero)
  );

  always #5 clk = ~clk;

  // Divider model: garbage until DELAY cycles after the start cycle, then the quotient.
  int               mdl_cnt;
  logic [WIDTH-1:0] mdl_res;
  logic signed [63:0] sa, sb;
  always @(posedge clk) begin
    if (reset) begin
      mdl_cnt      <= 0;
      div_quotient <= 32'hDEAD_BEEF;
    end else if (div_start) begin
      sa = $signed(div_dividend);
      sb = $signed({{32{div_divisor[31]}}, div_divisor});
      if (div_divisor == '0)  mdl_res <= '1;
      else if (div_is_signed) mdl_res <= WIDTH'(sa / sb);
      else                    mdl_res <= WIDTH'(div_dividend / {32'b0, div_divisor});
      mdl_cnt      <= DELAY;
      div_quotient <= 32'hDEAD_BEEF;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) div_quotient <= mdl_res;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Presents a request in cycle A; returns at the drive point of A+1.
  task automatic issue(input bit sg, input logic [31:0] dd, input logic [31:0] dv,
                       input logic [4:0] tg);
    to_cycle();
    req_valid = 1'b1; req_signed = sg; req_dividend = dd; req_divisor = dv; req_tag = tg;
    mid();
    check("req_ready_at_accept", 64'(req_ready), 64'd1);
    to_cycle();
    req_valid = 1'b0;
  endtask

  task automatic run_normal(input bit sg, input logic [31:0] dd, input logic [31:0] dv,
                            input logic [4:0] tg, input logic [63:0] exp_ext,
                            input logic [31:0] exp_q);
    issue(sg, dd, dv, tg);
    mid();
    check("start_a1", 64'(div_start), 64'd1);
    check("dividend_ext", div_dividend, exp_ext);
    check("divisor_out", 64'(div_divisor), 64'(dv));
    check("is_signed_out", 64'(div_is_signed), 64'(sg));
    for (int c = 2; c <= 10; c++) begin
      to_cycle(); mid();
      check("no_restart", 64'(div_start), 64'd0);
      check("no_early_valid", 64'(resp_valid), 64'd0);
    end
    to_cycle(); mid();
    check("resp_valid_a11", 64'(resp_valid), 64'd1);
    check("resp_quotient", 64'(resp_quotient), 64'(exp_q));
    check("resp_tag", 64'(resp_tag), 64'(tg));
    check("resp_dz_clear", 64'(resp_div_zero), 64'd0);
    to_cycle(); mid();
    check("idle_after_hs", 64'(resp_valid), 64'd0);
    check("ready_after_hs", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
    req_dividend = '0; req_divisor = '0; req_tag = '0; resp_ready = 1'b1;

    to_cycle(); to_cycle(); mid();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_quotient", 64'(resp_quotient), 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_resp_dz", 64'(resp_div_zero), 64'd0);
    check("rst_div_start", 64'(div_start), 64'd0);
    check("rst_div_dividend", div_dividend, 64'd0);
    check("rst_div_divisor", 64'(div_divisor), 64'd0);
    check("rst_div_signed", 64'(div_is_signed), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    to_cycle();
    reset = 1'b0;
    mid();
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Unsigned and signed divides through the divider.
    run_normal(1'b0, 32'd100, 32'd7, 5'd3, 64'd100, 32'd14);
    run_normal(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF2);

    // Divide by zero bypass.
    issue(1'b0, 32'd5, 32'd0, 5'd1);
    mid();
    check("dz_valid_a1", 64'(resp_valid), 64'd1);
    check("dz_quotient", 64'(resp_quotient), 64'hFFFF_FFFF);
    check("dz_flag", 64'(resp_div_zero), 64'd1);
    check("dz_tag", 64'(resp_tag), 64'd1);
    check("dz_no_start", 64'(div_start), 64'd0);
    to_cycle(); mid();
    check("dz_ready_after", 64'(req_ready), 64'd1);
    check("dz_no_start_after", 64'(div_start), 64'd0);

    // Signed overflow bypass, then the same operands unsigned.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    mid();
    check("ovf_valid_a1", 64'(resp_valid), 64'd1);
    check("ovf_quotient", 64'(resp_quotient), 64'h8000_0000);
    check("ovf_dz_clear", 64'(resp_div_zero), 64'd0);
    check("ovf_no_start", 64'(div_start), 64'd0);
    to_cycle(); mid();
    check("ovf_ready_after", 64'(req_ready), 64'd1);
    run_normal(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 64'h0000_0000_8000_0000, 32'd0);

    // Flush in WAIT (cycle A+4).
    issue(1'b0, 32'd100, 32'd7, 5'd4);
    mid();
    check("fl_ready_a1", 64'(req_ready), 64'd0);
    for (int c = 2; c <= 10; c++) begin
      to_cycle();
      flush = (c == 4);
      mid();
      check("fl_no_valid", 64'(resp_valid), 64'd0);
      check("fl_ready_low", 64'(req_ready), 64'd0);
    end
    to_cycle();
    flush = 1'b0;
    mid();
    check("fl_ready_a11", 64'(req_ready), 64'd1);
    check("fl_no_valid_a11", 64'(resp_valid), 64'd0);
    run_normal(1'b0, 32'd50, 32'd5, 5'd6, 64'd50, 32'd10);

    // Consumer back-pressure for five cycles, handshake on the sixth.
    resp_ready = 1'b0;
    issue(1'b0, 32'd40, 32'd8, 5'd7);
    for (int c = 1; c <= 10; c++) begin
      mid();
      check("bp_no_valid", 64'(resp_valid), 64'd0);
      to_cycle();
    end
    for (int c = 11; c <= 15; c++) begin
      mid();
      check("bp_valid_hold", 64'(resp_valid), 64'd1);
      check("bp_quotient_hold", 64'(resp_quotient), 64'd5);
      check("bp_tag_hold", 64'(resp_tag), 64'd7);
      check("bp_ready_low", 64'(req_ready), 64'd0);
      to_cycle();
    end
    resp_ready = 1'b1;
    mid();
    check("bp_valid_a16", 64'(resp_valid), 64'd1);
    to_cycle();
    resp_ready = 1'b0;
    mid();
    check("bp_valid_gone", 64'(resp_valid), 64'd0);
    check("bp_ready_back", 64'(req_ready), 64'd1);

    // Flush during RESP drops the response.
    issue(1'b0, 32'd9, 32'd0, 5'd8);
    mid();
    check("fr_valid_a1", 64'(resp_valid), 64'd1);
    to_cycle();
    flush = 1'b1;
    mid();
    check("fr_valid_a2", 64'(resp_valid), 64'd1);
    check("fr_ready_blocked", 64'(req_ready), 64'd0);
    to_cycle();
    flush = 1'b0;
    mid();
    check("fr_dropped", 64'(resp_valid), 64'd0);
    check("fr_ready", 64'(req_ready), 64'd1);

    // Flush during ISSUE suppresses the start pulse.
    resp_ready = 1'b1;
    issue(1'b0, 32'd20, 32'd3, 5'd10);
    flush = 1'b1;
    mid();
    check("fi_no_start", 64'(div_start), 64'd0);
    to_cycle();
    flush = 1'b0;
    mid();
    check("fi_ready", 64'(req_ready), 64'd1);
    check("fi_no_valid", 64'(resp_valid), 64'd0);
    check("fi_no_start_after", 64'(div_start), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
